shift_right_unit: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 22 ++
 rtl/shr_stage.sv | 48 ++++
 rtl/shift_right_unit.sv | 146 ++++++++++++++
 tb/tb_shift_right_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shared definitions for the ALU right-shift unit.
//   SHR_WIDTH     default datapath width
//   shift_mode_t  2-bit operation select (SRL / SRA / ROR / reserved)
//   is_sra()      true when the vacated MSBs take the sign bit
package alu_shift_pkg;

   localparam int SHR_WIDTH = 16;

   // A plain 2-bit type rather than an enum: the reserved code 2'b11 must
   // flow through the datapath untouched and behave like SRL.
   typedef logic [1:0] shift_mode_t;

   localparam shift_mode_t SH_SRL = 2'b00;
   localparam shift_mode_t SH_SRA = 2'b01;
   localparam shift_mode_t SH_ROR = 2'b10;
   localparam shift_mode_t SH_RSV = 2'b11;

   function automatic logic is_sra(input shift_mode_t mode);
      return (mode == SH_SRA);
   endfunction

endpackage

// File: rtl/shr_stage.sv
// shr_stage: combinational right shift by k*STEP positions.
//   data_i  value to shift
//   k_i     shift multiplier (0 .. 2**KW-1)
//   mode_i  SRL / SRA / ROR (reserved code behaves as SRL)
//   fill_i  sign bit used for SRA vacated positions
//   data_o  shifted value
// Each output bit is a small mux over the candidate source bits, one per
// value of k, so the stage is a single mux level per bit.
module shr_stage
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = SHR_WIDTH,
   parameter int STEP  = 1,
   parameter int KW    = 2
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [KW-1:0]    k_i,
   input  shift_mode_t      mode_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int NK = 1 << KW;

   logic vac_bit;
   logic rot;

   assign vac_bit = is_sra(mode_i) ? fill_i : 1'b0;
   assign rot     = (mode_i == SH_ROR);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [NK-1:0] cand;
         for (genvar ki = 0; ki < NK; ki++) begin : g_k
            localparam int SRC = gi + ki * STEP;
            if (SRC < WIDTH) begin : g_in
               assign cand[ki] = data_i[SRC];
            end else begin : g_vac
               // Source fell off the top: rotate wraps from the LSB end,
               // the other modes insert the fill bit.
               assign cand[ki] = rot ? data_i[SRC % WIDTH] : vac_bit;
            end
         end
         assign data_o[gi] = cand[k_i];
      end
   endgenerate

endmodule

// File: rtl/shift_right_unit.sv
// shift_right_unit: 2-stage pipelined right shifter (SRL / SRA / ROR).
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake
//   in_data, in_shamt      value and shift amount (0 .. WIDTH-1)
//   in_mode                00 SRL, 01 SRA, 10 ROR, 11 treated as SRL
//   out_valid/out_ready    result handshake
//   out_data               shifted result
//   out_carry              last bit shifted out (0 for shift of zero)
//   out_zero               out_data == 0
// Stage 1 shifts by shamt[1:0] and resolves the carry; stage 2 shifts by
// 4*shamt[SHW-1:2]. Two operations can be held while the output stalls.
module shift_right_unit
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = SHR_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   // Width of the coarse shift field; kept at least 1 so the smallest
   // legal WIDTH (4) still elaborates with a zero-valued coarse field.
   localparam int HIW = (SHW > 2) ? SHW - 2 : 1;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_data_q,  s1_data_d;
   logic             s1_carry_q, s1_carry_d;
   shift_mode_t      s1_mode_q,  s1_mode_d;
   logic [HIW-1:0]   s1_hi_q,    s1_hi_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             out_carry_q, out_carry_d;
   logic             out_zero_q,  out_zero_d;

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] s1_shift, s2_shift;
   logic [SHW-1:0]   carry_idx, shamt_hi_full;
   logic [HIW-1:0]   in_hi;
   logic             in_carry;
   shift_mode_t      mode_in;

   assign mode_in = shift_mode_t'(in_mode);

   shr_stage #(
      .WIDTH (WIDTH),
      .STEP  (1),
      .KW    (2)
   ) u_s1_shift (
      .data_i (in_data),
      .k_i    (in_shamt[1:0]),
      .mode_i (mode_in),
      .fill_i (in_data[WIDTH-1]),
      .data_o (s1_shift)
   );

   // SRA never alters the MSB in stage 1, so the stored MSB is still the
   // original sign and serves as the stage-2 fill bit.
   shr_stage #(
      .WIDTH (WIDTH),
      .STEP  (4),
      .KW    (HIW)
   ) u_s2_shift (
      .data_i (s1_data_q),
      .k_i    (s1_hi_q),
      .mode_i (s1_mode_q),
      .fill_i (s1_data_q[WIDTH-1]),
      .data_o (s2_shift)
   );

   always_comb begin
      s2_adv = !out_valid_q | out_ready;
      s1_adv = !s1_valid_q | s2_adv;

      // Carry is the bit just below the shift amount in the original
      // operand, identical for every mode.
      carry_idx     = in_shamt - SHW'(1);
      in_carry      = (in_shamt != '0) ? in_data[carry_idx] : 1'b0;
      shamt_hi_full = in_shamt >> 2;
      in_hi         = shamt_hi_full[HIW-1:0];

      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_carry_d = s1_carry_q;
      s1_mode_d  = s1_mode_q;
      s1_hi_d    = s1_hi_q;
      if (s1_adv && in_valid) begin
         s1_data_d  = s1_shift;
         s1_carry_d = in_carry;
         s1_mode_d  = mode_in;
         s1_hi_d    = in_hi;
      end

      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
      out_data_d  = out_data_q;
      out_carry_d = out_carry_q;
      out_zero_d  = out_zero_q;
      if (s2_adv && s1_valid_q) begin
         out_data_d  = s2_shift;
         out_carry_d = s1_carry_q;
         out_zero_d  = (s2_shift == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_carry_q  <= 1'b0;
         s1_mode_q   <= SH_SRL;
         s1_hi_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_zero_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_carry_q  <= s1_carry_d;
         s1_mode_q   <= s1_mode_d;
         s1_hi_q     <= s1_hi_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_carry_q <= out_carry_d;
         out_zero_q  <= out_zero_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: scoreboard bench for shift_right_unit.
// The driver pushes the expected result when an operand is accepted; an
// independent monitor pops and compares whenever a result is accepted.
module tb_shift_right_unit;
   import alu_shift_pkg::*;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         c;
      logic         z;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [3:0]   in_shamt = '0;
   logic [1:0]   in_mode = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_carry;
   logic         out_zero;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   logic rand_ready = 1'b0;
   logic forced_ready = 1'b1;
   logic bp_armed = 1'b0;
   int   bp_accepts = 0;

   shift_right_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference: plain arithmetic on the operand value.
   function automatic exp_t model(input logic [W-1:0] d, input int s, input logic [1:0] m);
      exp_t        e;
      int          sv;
      logic [31:0] u;
      u = {16'h0, d};
      case (m)
         2'b01: begin
            sv  = d[W-1] ? int'(u) - 65536 : int'(u);
            e.d = 16'(sv >>> s);
         end
         2'b10:   e.d = 16'((u >> s) | (u << (16 - s)));
         default: e.d = 16'(u >> s);
      endcase
      e.c = (s == 0) ? 1'b0 : u[s-1];
      e.z = (e.d == 16'h0);
      return e;
   endfunction

   // out_ready is driven only here; the main thread steers it through
   // rand_ready / forced_ready.
   initial begin
      forever begin
         @(negedge clk);
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [3:0] s, input logic [1:0] m,
                       input exp_t e);
      int waited = 0;
      bit done = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
      while (!done) begin
         #1;
         if (in_ready) begin
            sb_q.push_back(e);
            if (bp_armed) bp_accepts++;
            done = 1;
            @(posedge clk);
            #1 in_valid = 1'b0;
         end else begin
            if (bp_armed) begin
               check("bp_accepts_before_stall", bp_accepts, 2);
               bp_armed = 1'b0;
            end
            waited++;
            if (waited > 50) begin
               checks++;
               failures++;
               $display("FAIL send_timeout actual=in_ready_low required=accept");
               in_valid = 1'b0;
               done = 1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb_q.size(), 0);
   endtask

   // Monitor: samples mid-low-phase, values hold through the next rising edge.
   initial begin
      exp_t         e;
      logic         held = 1'b0;
      logic [W-1:0] held_d = '0;
      logic         held_c = 1'b0;
      logic         held_z = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_valid", out_valid, 1);
               check("stall_data", out_data, held_d);
               check("stall_flags", {out_carry, out_zero}, {held_c, held_z});
            end
            held = out_valid && !out_ready;
            held_d = out_data;
            held_c = out_carry;
            held_z = out_zero;
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=0x%0h required=none", out_data);
               end else begin
                  e = sb_q.pop_front();
                  $display("txn out_data=0x%04h carry=%0d zero=%0d exp=0x%04h/%0d/%0d",
                           out_data, out_carry, out_zero, e.d, e.c, e.z);
                  check("out_data", out_data, e.d);
                  check("out_carry", out_carry, e.c);
                  check("out_zero", out_zero, e.z);
               end
            end
         end
      end
   end

   exp_t ex;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_carry", out_carry, 0);
      check("rst_out_zero", out_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);

      // First op with latency check
      ex = '{d: 16'h4000, c: 1'b1, z: 1'b0};
      send(16'h8001, 4'd1, SH_SRL, ex);
      @(negedge clk);
      #1 check("latency_after_accept_edge", out_valid, 0);
      @(negedge clk);
      #1 check("latency_next_edge", out_valid, 1);
      drain();

      // Directed vectors
      send(16'h8000, 4'd15, SH_SRA, '{d: 16'hFFFF, c: 1'b0, z: 1'b0});
      send(16'h7FFF, 4'd15, SH_SRA, '{d: 16'h0000, c: 1'b1, z: 1'b1});
      send(16'h1234, 4'd4,  SH_ROR, '{d: 16'h4123, c: 1'b0, z: 1'b0});
      send(16'h0001, 4'd1,  SH_ROR, '{d: 16'h8000, c: 1'b1, z: 1'b0});
      send(16'hF0F0, 4'd0,  SH_RSV, '{d: 16'hF0F0, c: 1'b0, z: 1'b0});
      send(16'h0000, 4'd7,  SH_SRL, '{d: 16'h0000, c: 1'b0, z: 1'b1});
      drain();

      // Backpressure: out_ready low while 4 ops are offered back to back
      forced_ready = 1'b0;
      repeat (2) @(negedge clk);
      bp_accepts = 0;
      bp_armed = 1'b1;
      fork
         begin
            send(16'h00FF, 4'd1, SH_SRL, '{d: 16'h007F, c: 1'b1, z: 1'b0});
            send(16'h00FF, 4'd2, SH_SRL, '{d: 16'h003F, c: 1'b1, z: 1'b0});
            send(16'h00FF, 4'd3, SH_SRL, '{d: 16'h001F, c: 1'b1, z: 1'b0});
            send(16'h00FF, 4'd4, SH_SRL, '{d: 16'h000F, c: 1'b1, z: 1'b0});
         end
         begin
            repeat (5) @(negedge clk);
            forced_ready = 1'b1;
         end
      join
      check("bp_stall_seen", bp_armed, 0);
      drain();

      // Reset with two ops in flight
      forced_ready = 1'b0;
      repeat (2) @(negedge clk);
      send(16'hABCD, 4'd3, SH_SRA, model(16'hABCD, 3, SH_SRA));
      send(16'h1357, 4'd9, SH_ROR, model(16'h1357, 9, SH_ROR));
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_out_data", out_data, 0);
      sb_q.delete();
      forced_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_mid_in_ready", in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 check("rst_idle_out_valid", out_valid, 0);
      end
      send(16'h0F00, 4'd8, SH_SRL, '{d: 16'h000F, c: 1'b0, z: 1'b0});
      drain();

      // Randomized traffic with random output backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] d;
         int           s;
         logic [1:0]   m;
         d = W'($urandom);
         s = $urandom_range(0, 15);
         m = 2'($urandom_range(0, 3));
         send(d, 4'(s), m, model(d, s, m));
         if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
      rand_ready = 1'b0;
      forced_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
